// File: rtl/ps2_mouse_tracker_pkg.sv
// rtl/ps2_mouse_tracker_pkg.sv - PS/2 frame constants, packet header field positions, defaults and helpers
// Ports: none (package imported by ps2_rx_byte and ps2_mouse_tracker)
package ps2_mouse_tracker_pkg;

    // PS/2 frame layout after the start bit: 8 data bits, parity, stop.
    // Values are strobe indices counted from the first data bit.
    localparam int DATA_BITS  = 8;
    localparam int PARITY_IDX = 8;
    localparam int STOP_IDX   = 9;

    // Byte0 (packet header) field positions
    localparam int B0_LEFT   = 0;
    localparam int B0_RIGHT  = 1;
    localparam int B0_MIDDLE = 2;
    localparam int B0_SYNC   = 3;
    localparam int B0_XSIGN  = 4;
    localparam int B0_YSIGN  = 5;
    localparam int B0_XOVF   = 6;
    localparam int B0_YOVF   = 7;

    // Default geometry and timing
    localparam int DEF_MAX_X   = 767;
    localparam int DEF_MAX_Y   = 511;
    localparam int DEF_INIT_X  = 384;
    localparam int DEF_INIT_Y  = 256;
    localparam int DEF_TIMEOUT = 100_000;

    // Position register width and the signed width used for position sums;
    // 14 bits covers 0..4095 +/- 256 without wrapping.
    localparam int POS_W = 12;
    localparam int SUM_W = 14;

    typedef enum logic {
        RX_IDLE,
        RX_SHIFT
    } rx_state_t;

    typedef enum logic [1:0] {
        WAIT_B0,
        WAIT_B1,
        WAIT_B2
    } pkt_state_t;

    // Header fields kept between byte0 and byte2
    typedef struct packed {
        logic y_ovf;
        logic x_ovf;
        logic y_sign;
        logic x_sign;
        logic middle;
        logic right;
        logic left;
    } hdr_t;

    localparam logic signed [SUM_W-1:0] SUM_ZERO = '0;

    // Saturate a signed sum into 0..max_val.
    function automatic logic [POS_W-1:0] clamp_axis(
        input logic signed [SUM_W-1:0] sum,
        input logic [POS_W-1:0]        max_val
    );
        logic [POS_W-1:0] res;
        if (sum < SUM_ZERO) begin
            res = '0;
        end else if (sum > $signed({2'b00, max_val})) begin
            res = max_val;
        end else begin
            res = sum[POS_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/ps2_rx_byte.sv
// rtl/ps2_rx_byte.sv - PS/2 device-to-host frame receiver with synchronizers and idle timeout
// Ports:
//   CLOCK, RESETN          system clock, async active-low reset
//   ps2_clk, ps2_data      raw asynchronous PS/2 lines
//   byte_data[7:0]         received byte, valid while byte_valid is high
//   byte_valid             high in the cycle of the stop-bit strobe of a good frame
//   byte_err               high in the cycle of a bad parity/stop strobe or a timeout
module ps2_rx_byte
    import ps2_mouse_tracker_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic       CLOCK,
    input  logic       RESETN,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_err
);

    localparam int            TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    logic          clk_meta;
    logic          clk_sync;
    logic          clk_prev;
    logic          dat_meta;
    logic          dat_sync;
    rx_state_t     state;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          parity_bit;
    logic [TW-1:0] idle_cnt;

    logic fall;
    logic stop_strobe;
    logic frame_ok;
    logic timed_out;

    // Two-flop synchronizers plus one delay flop on the clock for edge detect.
    // All idle high so a reset never fabricates a falling edge.
    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= ps2_clk;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= ps2_data;
            dat_sync <= dat_meta;
        end
    end

    assign fall        = clk_prev & ~clk_sync;
    assign stop_strobe = fall && (state == RX_SHIFT) && (bit_cnt == 4'(STOP_IDX));
    // Odd parity across data and parity bit, and stop bit must be 1
    assign frame_ok    = (^{shreg, parity_bit}) & dat_sync;
    assign timed_out   = (state == RX_SHIFT) && !fall && (idle_cnt == TO_LAST);

    // Results are issued in the strobe cycle so the consumer can register
    // them and respond one cycle after the final strobe.
    assign byte_data  = shreg;
    assign byte_valid = stop_strobe & frame_ok;
    assign byte_err   = (stop_strobe & ~frame_ok) | timed_out;

    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            state      <= RX_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            idle_cnt   <= '0;
        end else begin
            case (state)
                RX_IDLE: begin
                    idle_cnt <= '0;
                    if (fall && !dat_sync) begin
                        state   <= RX_SHIFT;
                        bit_cnt <= '0;
                    end
                end
                RX_SHIFT: begin
                    if (fall) begin
                        idle_cnt <= '0;
                        if (bit_cnt < 4'(DATA_BITS)) begin
                            shreg <= {dat_sync, shreg[7:1]};
                        end else if (bit_cnt == 4'(PARITY_IDX)) begin
                            parity_bit <= dat_sync;
                        end
                        if (bit_cnt == 4'(STOP_IDX)) begin
                            state <= RX_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else if (timed_out) begin
                        state    <= RX_IDLE;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/ps2_mouse_tracker.sv
// rtl/ps2_mouse_tracker.sv - PS/2 mouse packet decoder with clamped X/Y position accumulator
// Ports:
//   CLOCK, RESETN                      system clock, async active-low reset
//   ps2_clk, ps2_data                  raw PS/2 lines from the mouse
//   mouse_x[11:0], mouse_y[11:0]       accumulated position (Y grows downward)
//   btn_left, btn_right, btn_middle    button state from the last applied packet
//   packet_valid                       one-cycle pulse when a packet is applied
//   frame_err                          one-cycle pulse on parity/stop/timeout error
module ps2_mouse_tracker
    import ps2_mouse_tracker_pkg::*;
#(
    parameter int MAX_X   = DEF_MAX_X,
    parameter int MAX_Y   = DEF_MAX_Y,
    parameter int INIT_X  = DEF_INIT_X,
    parameter int INIT_Y  = DEF_INIT_Y,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic        CLOCK,
    input  logic        RESETN,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [11:0] mouse_x,
    output logic [11:0] mouse_y,
    output logic        btn_left,
    output logic        btn_right,
    output logic        btn_middle,
    output logic        packet_valid,
    output logic        frame_err
);

    localparam logic [POS_W-1:0] MAX_X_P  = POS_W'(MAX_X);
    localparam logic [POS_W-1:0] MAX_Y_P  = POS_W'(MAX_Y);
    localparam logic [POS_W-1:0] INIT_X_P = POS_W'(INIT_X);
    localparam logic [POS_W-1:0] INIT_Y_P = POS_W'(INIT_Y);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;

    pkt_state_t pkt_state;
    hdr_t       hdr;
    logic [7:0] byte1;

    logic signed [SUM_W-1:0] dx;
    logic signed [SUM_W-1:0] dy;
    logic signed [SUM_W-1:0] sum_x;
    logic signed [SUM_W-1:0] sum_y;

    ps2_rx_byte #(
        .TIMEOUT (TIMEOUT)
    ) u_rx (
        .CLOCK      (CLOCK),
        .RESETN     (RESETN),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_data  (rx_data),
        .byte_valid (rx_valid),
        .byte_err   (rx_err)
    );

    // Movement is 9-bit two's complement: sign from the header, magnitude
    // byte from byte1/byte2. byte2 is consumed straight from the receiver
    // in the cycle it completes. Y is subtracted because the mouse reports
    // up as positive while screen Y grows downward.
    always_comb begin
        dx    = {{5{hdr.x_sign}}, hdr.x_sign, byte1};
        dy    = {{5{hdr.y_sign}}, hdr.y_sign, rx_data};
        sum_x = $signed({2'b00, mouse_x}) + dx;
        sum_y = $signed({2'b00, mouse_y}) - dy;
    end

    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            pkt_state    <= WAIT_B0;
            hdr          <= '0;
            byte1        <= '0;
            mouse_x      <= INIT_X_P;
            mouse_y      <= INIT_Y_P;
            btn_left     <= 1'b0;
            btn_right    <= 1'b0;
            btn_middle   <= 1'b0;
            packet_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            packet_valid <= 1'b0;
            frame_err    <= 1'b0;
            if (rx_err) begin
                // A corrupt or abandoned frame breaks packet alignment
                frame_err <= 1'b1;
                pkt_state <= WAIT_B0;
            end else if (rx_valid) begin
                case (pkt_state)
                    WAIT_B0: begin
                        // Header always has bit3 set; anything else is a
                        // stray byte and is skipped to regain alignment.
                        if (rx_data[B0_SYNC]) begin
                            hdr.left   <= rx_data[B0_LEFT];
                            hdr.right  <= rx_data[B0_RIGHT];
                            hdr.middle <= rx_data[B0_MIDDLE];
                            hdr.x_sign <= rx_data[B0_XSIGN];
                            hdr.y_sign <= rx_data[B0_YSIGN];
                            hdr.x_ovf  <= rx_data[B0_XOVF];
                            hdr.y_ovf  <= rx_data[B0_YOVF];
                            pkt_state  <= WAIT_B1;
                        end
                    end
                    WAIT_B1: begin
                        byte1     <= rx_data;
                        pkt_state <= WAIT_B2;
                    end
                    WAIT_B2: begin
                        if (!hdr.x_ovf) begin
                            mouse_x <= clamp_axis(sum_x, MAX_X_P);
                        end
                        if (!hdr.y_ovf) begin
                            mouse_y <= clamp_axis(sum_y, MAX_Y_P);
                        end
                        btn_left     <= hdr.left;
                        btn_right    <= hdr.right;
                        btn_middle   <= hdr.middle;
                        packet_valid <= 1'b1;
                        pkt_state    <= WAIT_B0;
                    end
                    default: begin
                        pkt_state <= WAIT_B0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// tb/tb_ps2_mouse_tracker.sv - scoreboard bench for ps2_mouse_tracker
module tb_ps2_mouse_tracker;

    localparam int TO     = 1000;
    localparam int HALF   = 6;
    localparam int MAXX   = 767;
    localparam int MAXY   = 511;
    localparam int INITX  = 384;
    localparam int INITY  = 256;

    logic        CLOCK    = 1'b0;
    logic        RESETN   = 1'b1;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [11:0] mouse_x;
    logic [11:0] mouse_y;
    logic        btn_left;
    logic        btn_right;
    logic        btn_middle;
    logic        packet_valid;
    logic        frame_err;

    ps2_mouse_tracker #(
        .MAX_X   (MAXX),
        .MAX_Y   (MAXY),
        .INIT_X  (INITX),
        .INIT_Y  (INITY),
        .TIMEOUT (TO)
    ) dut (
        .CLOCK        (CLOCK),
        .RESETN       (RESETN),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .mouse_x      (mouse_x),
        .mouse_y      (mouse_y),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_middle   (btn_middle),
        .packet_valid (packet_valid),
        .frame_err    (frame_err)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        int x;
        int y;
        int btns;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur;
    int         exp_errs = 0;
    int         checks   = 0;
    int         errors   = 0;
    int         m_x;
    int         m_y;
    logic [7:0] pend[$];
    int         prev_state = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int clampi(input int v, input int mx);
        if (v < 0) return 0;
        if (v > mx) return mx;
        return v;
    endfunction

    function automatic void model_reset();
        m_x = INITX;
        m_y = INITY;
        pend.delete();
        exp_q.delete();
        exp_errs = 0;
    endfunction

    // Byte-level reference: accepted bytes collect into a 3-byte packet,
    // a bad byte throws away whatever was collected.
    function automatic void model_byte(input logic [7:0] b, input bit ok);
        logic [7:0] h;
        int         dx;
        int         dy;
        exp_t       e;
        if (!ok) begin
            pend.delete();
            exp_errs++;
            return;
        end
        if (pend.size() == 0 && !b[3]) return;
        pend.push_back(b);
        if (pend.size() == 3) begin
            h  = pend[0];
            dx = int'(pend[1]) - (h[4] ? 256 : 0);
            dy = int'(pend[2]) - (h[5] ? 256 : 0);
            if (!h[6]) m_x = clampi(m_x + dx, MAXX);
            if (!h[7]) m_y = clampi(m_y - dy, MAXY);
            e.x    = m_x;
            e.y    = m_y;
            e.btns = int'(h[2:0]);
            exp_q.push_back(e);
            pend.delete();
        end
    endfunction

    // Monitor: compares every applied packet and error pulse with the
    // scoreboard, and requires outputs to hold still between packets.
    always @(negedge CLOCK) begin
        if (RESETN) begin
            if (packet_valid) begin
                check("packet_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    check("pkt_x", int'(mouse_x), cur.x);
                    check("pkt_y", int'(mouse_y), cur.y);
                    check("pkt_btns", int'({btn_middle, btn_right, btn_left}), cur.btns);
                end
            end else begin
                check("outputs_stable",
                      int'({mouse_x, mouse_y, btn_middle, btn_right, btn_left}), prev_state);
            end
            if (frame_err) begin
                check("frame_err_expected", int'(exp_errs > 0), 1);
                if (exp_errs > 0) exp_errs--;
            end
        end
        prev_state = int'({mouse_x, mouse_y, btn_middle, btn_right, btn_left});
    end

    task automatic ps2_bit(input bit v);
        ps2_data = v;
        repeat (HALF) @(posedge CLOCK);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge CLOCK);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = (~^b) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_data = ~bad_stop;
        repeat (HALF) @(posedge CLOCK);
        model_byte(b, !bad_par && !bad_stop);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge CLOCK);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (2 * HALF) @(posedge CLOCK);
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 1'b0, 1'b0);
        send_byte(b1, 1'b0, 1'b0);
        send_byte(b2, 1'b0, 1'b0);
    endtask

    task automatic settle();
        repeat (20) @(posedge CLOCK);
    endtask

    task automatic do_reset();
        RESETN = 1'b0;
        #1;
        check("rst_x", int'(mouse_x), INITX);
        check("rst_y", int'(mouse_y), INITY);
        check("rst_btns", int'({btn_middle, btn_right, btn_left}), 0);
        check("rst_packet_valid", int'(packet_valid), 0);
        check("rst_frame_err", int'(frame_err), 0);
        model_reset();
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        RESETN = 1'b1;
        repeat (4) @(posedge CLOCK);
    endtask

    initial begin
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         r;

        #3;
        do_reset();

        // Basic packet from reset
        send_packet(8'h09, 8'h05, 8'h03);
        settle();
        check("basic_x", int'(mouse_x), 389);
        check("basic_y", int'(mouse_y), 253);
        check("basic_left", int'(btn_left), 1);

        // Clamping at MAX_X and at 0
        do_reset();
        send_packet(8'h08, 8'hFF, 8'h00);
        send_packet(8'h08, 8'h79, 8'h00);
        settle();
        check("pre_clamp_x", int'(mouse_x), 760);
        send_packet(8'h08, 8'h20, 8'h00);
        settle();
        check("clamp_max_x", int'(mouse_x), MAXX);
        send_packet(8'h18, 8'h00, 8'h00);
        send_packet(8'h18, 8'h00, 8'h00);
        send_packet(8'h18, 8'h65, 8'h00);
        settle();
        check("x_at_100", int'(mouse_x), 100);
        send_packet(8'h18, 8'h00, 8'h00);
        send_packet(8'h18, 8'h00, 8'h00);
        settle();
        check("clamp_zero_x", int'(mouse_x), 0);

        // Bad parity on a header, then a good packet
        do_reset();
        send_byte(8'h08, 1'b1, 1'b0);
        send_packet(8'h08, 8'h01, 8'h01);
        settle();
        check("after_parity_x", int'(mouse_x), INITX + 1);
        check("after_parity_y", int'(mouse_y), INITY - 1);

        // Stray non-header byte is skipped silently
        do_reset();
        send_byte(8'h00, 1'b0, 1'b0);
        send_packet(8'h0A, 8'h00, 8'h00);
        settle();
        check("stray_right", int'(btn_right), 1);
        check("stray_x", int'(mouse_x), INITX);
        check("stray_y", int'(mouse_y), INITY);

        // Timeout in the middle of byte1
        send_byte(8'h08, 1'b0, 1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        model_byte(8'h00, 1'b0);
        repeat (TO + 60) @(posedge CLOCK);
        check("timeout_err_seen", exp_errs, 0);
        send_packet(8'h09, 8'h02, 8'hFE);
        settle();
        check("after_timeout_x", int'(mouse_x), INITX + 2);
        check("after_timeout_y", int'(mouse_y), INITY - 254);

        // X overflow keeps X; then reset in the middle of a byte
        do_reset();
        send_packet(8'h09, 8'h05, 8'h03);
        send_packet(8'h48, 8'h7F, 8'h10);
        settle();
        check("ovf_x", int'(mouse_x), 389);
        check("ovf_y", int'(mouse_y), 253 - 16);
        send_packet(8'h0B, 8'h03, 8'h00);
        settle();
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        do_reset();

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            r  = $urandom_range(0, 9);
            b0 = 8'($urandom) | 8'h08;
            if ($urandom_range(0, 3) != 0) b0 = b0 & 8'h3F;
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            if (r == 0) begin
                send_byte(8'($urandom) & 8'hF7, 1'b0, 1'b0);
            end else if (r == 1) begin
                send_byte(b0, 1'b1, 1'b0);
            end else if (r == 2) begin
                send_byte(b0, 1'b0, 1'b0);
                send_byte(b1, 1'b0, 1'b1);
            end
            send_packet(b0, b1, b2);
        end
        settle();

        check("pending_packets", exp_q.size(), 0);
        check("pending_errs", exp_errs, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
